// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S serial-to-parallel receiver.
// Oversamples sclk/lrclk/sdata in the clk domain, rebuilds signed left/right
// sample pairs and presents them on a valid/ready interface. Truncated words
// raise frame_err; completed pairs that cannot be presented raise overflow.
module i2s_rx_deser #(
    parameter int DATA_WIDTH  = 16,
    parameter int I2S_DELAY   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        SYNC,
        RX
    } state_t;

    // Input synchronizers and sclk edge detect
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] lr_q;
    logic [SYNC_STAGES-1:0] sd_q;
    logic                   sclk_d;
    logic                   sclk_s;
    logic                   lr_s;
    logic                   sd_s;
    logic                   rise;

    // Capture state
    state_t                 state;
    state_t                 state_nx;
    logic [DATA_WIDTH-1:0]  sr;
    logic [DATA_WIDTH-1:0]  sr_nx;
    logic [CW-1:0]          bit_cnt;
    logic [CW-1:0]          cnt_nx;
    logic                   cur_ch;
    logic                   ch_nx;
    logic                   lr_prev;
    logic [DATA_WIDTH-1:0]  left_hold;
    logic [DATA_WIDTH-1:0]  lhold_nx;
    logic                   left_have;
    logic                   lhave_nx;

    // Registered word/pair events handed to the output stage
    logic                   pair_stb;
    logic                   pair_nx;
    logic                   short_stb;
    logic                   short_nx;
    logic [DATA_WIDTH-1:0]  pair_l;
    logic [DATA_WIDTH-1:0]  pl_nx;
    logic [DATA_WIDTH-1:0]  pair_r;
    logic [DATA_WIDTH-1:0]  pr_nx;

    // Combinational helpers
    logic                   boundary;
    logic [DATA_WIDTH-1:0]  sr_sh;
    logic [DATA_WIDTH-1:0]  word_val;
    logic                   word_done;
    logic                   word_short;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign lr_s   = lr_q[SYNC_STAGES-1];
    assign sd_s   = sd_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;

    // Bring the serial pins into the clk domain and delay sclk once for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= '0;
            lr_q   <= '0;
            sd_q   <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            lr_q   <= {lr_q[SYNC_STAGES-2:0], lrclk};
            sd_q   <= {sd_q[SYNC_STAGES-2:0], sdata};
            sclk_d <= sclk_s;
        end
    end

    // Capture state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SYNC;
            sr        <= '0;
            bit_cnt   <= '0;
            cur_ch    <= 1'b0;
            lr_prev   <= 1'b1;
            left_hold <= '0;
            left_have <= 1'b0;
            pair_stb  <= 1'b0;
            short_stb <= 1'b0;
            pair_l    <= '0;
            pair_r    <= '0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            bit_cnt   <= cnt_nx;
            cur_ch    <= ch_nx;
            if (rise) begin
                lr_prev <= lr_s;
            end
            left_hold <= lhold_nx;
            left_have <= lhave_nx;
            pair_stb  <= pair_nx;
            short_stb <= short_nx;
            pair_l    <= pl_nx;
            pair_r    <= pr_nx;
        end
    end

    // Next-state: word framing, shifting, completion and pairing on each sclk rise
    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        cnt_nx     = bit_cnt;
        ch_nx      = cur_ch;
        lhold_nx   = left_hold;
        lhave_nx   = left_have;
        pair_nx    = 1'b0;
        short_nx   = 1'b0;
        pl_nx      = pair_l;
        pr_nx      = pair_r;
        boundary   = (lr_s != lr_prev);
        sr_sh      = {sr[DATA_WIDTH-2:0], sd_s};
        word_val   = sr;
        word_done  = 1'b0;
        word_short = 1'b0;

        if (rise) begin
            unique case (state)
                SYNC: begin
                    // Capture begins only at a left start, so the first word is never partial
                    if (boundary && !lr_s) begin
                        state_nx = RX;
                        ch_nx    = 1'b0;
                        if (I2S_DELAY == 0) begin
                            sr_nx    = '0;
                            sr_nx[0] = sd_s;
                            cnt_nx   = CNT_ONE;
                        end else begin
                            cnt_nx = '0;
                        end
                    end
                end
                RX: begin
                    if (boundary) begin
                        if (I2S_DELAY != 0) begin
                            // The boundary bit is still the old word's LSB
                            if (bit_cnt < CNT_FULL) begin
                                word_val = sr_sh;
                                sr_nx    = sr_sh;
                                if (bit_cnt == CNT_LAST) begin
                                    word_done = 1'b1;
                                end else begin
                                    word_short = 1'b1;
                                end
                            end
                            cnt_nx = '0;
                        end else begin
                            // The boundary bit is the new word's MSB
                            if (bit_cnt < CNT_FULL) begin
                                word_short = 1'b1;
                            end
                            sr_nx    = '0;
                            sr_nx[0] = sd_s;
                            cnt_nx   = CNT_ONE;
                        end
                        ch_nx = lr_s;
                    end else if (bit_cnt < CNT_FULL) begin
                        sr_nx    = sr_sh;
                        cnt_nx   = bit_cnt + CNT_ONE;
                        word_val = sr_sh;
                        if (bit_cnt == CNT_LAST) begin
                            word_done = 1'b1;
                        end
                    end
                end
                default: state_nx = SYNC;
            endcase

            // Completion/short evaluation always refers to the channel of the old word
            if (word_done) begin
                if (!cur_ch) begin
                    lhold_nx = word_val;
                    lhave_nx = 1'b1;
                end else if (left_have) begin
                    pair_nx  = 1'b1;
                    pl_nx    = left_hold;
                    pr_nx    = word_val;
                    lhave_nx = 1'b0;
                end
            end
            if (word_short) begin
                short_nx = 1'b1;
                if (cur_ch) begin
                    lhave_nx = 1'b0;
                end
            end
        end
    end

    // Output stage: present pairs, handshake, and one-cycle error/overflow pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_data  <= '0;
            right_data <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err <= short_stb;
            overflow  <= 1'b0;
            if (pair_stb) begin
                if (!out_valid || out_ready) begin
                    left_data  <= pair_l;
                    right_data <= pair_r;
                    out_valid  <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_rx_deser.md
# i2s_rx_deser

I2S serial-to-parallel receiver that consumes the tone generator's serial output: bit clock, word-select and one serial data lane. It oversamples these signals in the system clock domain and rebuilds signed left/right sample pairs. Each pair goes out on a valid/ready interface to the downstream sample FIFO or loopback checker. It also flags truncated words and dropped pairs.

## Interface
- DATA_WIDTH, 16, bits per channel word, MSB first
- I2S_DELAY, 1, sclk periods between a word-select edge and the MSB (1 = Philips I2S, 0 = left-justified)
- SYNC_STAGES, 2, synchronizer depth on sclk/lrclk/sdata (minimum 2)

- clk  input  1  system clock; frequency ≥ 4× sclk
- reset_n  input  1  reset, asynchronous, active-low
- sclk  input  1  serial bit clock, asynchronous to clk
- lrclk  input  1  word select; 0 = left, 1 = right
- sdata  input  1  serial data; the transmitter changes it on the sclk falling edge
- left_data  output  DATA_WIDTH  left sample of the presented pair
- right_data  output  DATA_WIDTH  right sample of the presented pair
- out_valid  output  1  pair available
- out_ready  input  1  consumer accepts the pair
- frame_err  output  1  one-clk pulse: word ended short
- overflow  output  1  one-clk pulse: completed pair dropped because out_valid was held

## Operation
- **Input sync:** sclk, lrclk and sdata each pass through SYNC_STAGES flops.
- **Edge detect:** one further register on synced sclk. An sclk rise (`rise`) is synced 1 while the previous value was 0.
- All capture logic advances only on cycles where `rise` is 1. lrclk and sdata are sampled on that cycle.
- **Word boundary:** the sampled lrclk differs from lr_prev, the value sampled at the previous rise. lr_prev updates on every rise.
- **States:**
  - SYNC: entered on reset. Waits for a 1→0 boundary (left start), then goes to RX.
  - RX: shifts data in.
  - No other states.
- **RX shifting:**
  - Shift register sr (DATA_WIDTH bits, shifted left, sdata into the LSB).
  - Counter bit_cnt (clog2(DATA_WIDTH+1) bits) counts bits captured; it saturates at DATA_WIDTH.
  - Bits beyond DATA_WIDTH in a slot are ignored, so wider slots (e.g. 32-bit) are accepted.
  - A rise with bit_cnt < DATA_WIDTH shifts sr and increments bit_cnt.
- **Boundary rise, I2S_DELAY=1:**
  - The sampled bit belongs to the old word. Shift it first if bit_cnt < DATA_WIDTH.
  - Then evaluate the old word: complete if bit_cnt reached DATA_WIDTH, otherwise short.
  - Then clear bit_cnt to 0. The new channel is the sampled lrclk.
- **Boundary rise, I2S_DELAY=0:**
  - Evaluate the old word as-is.
  - The sampled bit is the new word's MSB: load sr with it and set bit_cnt = 1.
- **Completion:** a word completes on the rise where bit_cnt reaches DATA_WIDTH.
  - Left word: copied to left_hold; left_have set.
  - Right word with left_have = 1: forms a pair; left_have cleared.
  - Right word with left_have = 0: discarded.
- **Short word:** a boundary with bit_cnt < DATA_WIDTH from a word that had not completed.
  - Pulse frame_err.
  - Discard the word; a short right word also clears left_have.
  - Stay in RX.
  - No frame_err for the first partial word after leaving SYNC, since capture only starts at a boundary.
- **Pair output:**
  - If out_valid = 0, or out_valid and out_ready are both 1 on that cycle: load left_data/right_data and set out_valid.
  - Otherwise drop the pair, pulse overflow and leave the outputs unchanged.
- **Handshake:**
  - out_valid clears on a cycle with out_valid & out_ready and no new pair.
  - Data is stable while out_valid = 1 and out_ready = 0.
- Values are raw two's-complement; no sign extension or scaling.

## Timing
- **Reset values:** left_data = 0, right_data = 0, out_valid = 0, frame_err = 0, overflow = 0. Internal: state = SYNC, bit_cnt = 0, left_have = 0, lr_prev = 1, sync flops = 0.
- **Reset mid-word:** discards all partial data and any held pair. After release, the block resyncs on the next left start.
- **Latency:** out_valid rises SYNC_STAGES+2 clk cycles after the sclk pin rise that carries the right word's last bit.
- frame_err and overflow are exactly one clk wide. Both are registered and aligned with the cycle in which the pair or word would have loaded.
- **Simultaneous events:**
  - Pair completion and out_ready on the same cycle: new pair loaded, out_valid stays 1, no overflow.
  - frame_err and overflow cannot coincide for the same word.
- Sustained throughput: one pair per lrclk period with out_ready tied high.

## Test plan
- **Basic pair:** I2S_DELAY=1, 16-bit slots, left 0x10B4, right 0xEF4B, out_ready=1 → one out_valid pulse with left_data=0x10B4 and right_data=0xEF4B, SYNC_STAGES+2 clk after the last right-bit rise.
- **Startup sync:** reset released mid right word, then 3 full frames (0x0000/0x7FFF, 0x4000/0xC000, 0x2121/0x8001) → exactly 3 pairs in order; no frame_err.
- **Backpressure:** out_ready=0 across 2 frames (0x1111/0x2222, 0x3333/0x4444) → the outputs hold 0x1111/0x2222; one overflow pulse at the second pair. Raise out_ready → out_valid falls one clk later.
- **Short word:** left slot truncated to 12 bits → one frame_err pulse and no pair for that frame. The next full frame 0xAAAA/0x5555 is received correctly.
- **Wide slots / left-justified:** I2S_DELAY=0, 32-bit slots carrying 0x8000 then 16 zero bits, right 0x0001 → pair 0x8000/0x0001; the extra bits are ignored.
- **Reset mid-operation:** assert reset_n low at bit 7 of a right word while a pair is pending → out_valid=0 immediately and no stale pair after release. The first output is the next complete frame.
